ahb_mtx_input_stage: RTL and testbench
======================================

# ahb_mtx_input_stage

Bus-matrix input stage placed between one AHB master port and the matrix decoder/output stages; it is the requesting side that output-stage arbiters grant. Every address phase is forwarded live when the selected output stage can take it. When the output stage cannot take it, the address and control are captured into a hold register and the master is stalled until an arbiter grants the port. It also tracks the data phase and returns the granted output stage's HREADY/HRESP to the master.

## Interface
- ADDR_W, 32, address width
- HCLK  in  1  AHB clock
- HRESETn  in  1  reset, asynchronous, active-low; clock HCLK
- HSELS  in  1  master-side select
- HADDRS  in  ADDR_W  address
- HTRANSS  in  2  transfer type
- HWRITES  in  1  write
- HSIZES  in  3  size
- HBURSTS  in  3  burst type
- HPROTS  in  4  protection
- HMASTLOCKS  in  1  locked sequence
- HREADYS  in  1  bus HREADY seen by master
- HREADYOUTS  out  1  ready back to master
- HRESPS  out  1  response back to master (0 OKAY, 1 ERROR)
- sel_out  out  1  request to decoder/arbiters (becomes req_portN)
- addr_out, trans_out, write_out, size_out, burst_out, prot_out, mastlock_out  out  ADDR_W/2/1/3/3/4/1  forwarded address phase
- held_tran  out  1  forwarded fields come from the hold register
- active_in  in  1  an output stage has this port selected this cycle (addr_in_port matches, no_port low)
- readyout_in  in  1  HREADY from the data-phase output stage
- resp_in  in  1  HRESP from the data-phase output stage

## Operation
- live_tran = HSELS & HREADYS & HTRANSS[1] (NONSEQ/SEQ).
- addr_taken = active_in & readyout_in.
- Hold register: loads all address/control fields on every cycle with HSELS & HREADYS. It keeps its value otherwise.
- pend: next = live_tran ? ~addr_taken : (pend & ~addr_taken).
- Forwarding mux:
  - pend=1: outputs come from the hold register and held_tran=1.
  - pend=0: outputs are the live HxxxS inputs.
- sel_out = pend | live_tran (see Configuration).
- data_phase: next = addr_taken ? trans_out[1] : (readyout_in ? 0 : data_phase).
- HREADYOUTS:
  - data_phase=1: readyout_in
  - data_phase=0 and pend=1: 0
  - otherwise: 1
- HRESPS = data_phase ? resp_in : 0. A two-cycle ERROR passes through unchanged.
- pend and data_phase are never both 1. A hold only starts on a cycle with HREADYS high, which ends the prior data phase. The bench asserts this.
- Locked: mastlock_out follows the forwarded source. A held locked transfer keeps mastlock_out=1 until it is taken.
- BUSY/IDLE: never set pend and never start a data phase.
- Reset mid-hold: pend and data_phase are cleared immediately and asynchronously, and the held transfer is discarded.

## Timing
- Reset values:
  - pend=0, data_phase=0, hold register all 0
  - HREADYOUTS=1, HRESPS=0, sel_out=0, held_tran=0
  - trans_out=IDLE, addr_out=0
- Live pass-through: zero latency. Combinational from HxxxS to the outputs when pend=0.
- Held transfer:
  - HREADYOUTS goes low in the cycle after capture.
  - The held transfer is forwarded in that same cycle.
  - It is taken in the first cycle with addr_taken.
  - The data phase starts the following cycle, with HREADYOUTS=readyout_in.
- Simultaneous live_tran and addr_taken: no hold. pend stays 0.
- All registers update on posedge HCLK. The hold register is enabled by HSELS & HREADYS.

## Configuration
- AHB_MTX_IS_IDLE_HOLD_EN:
  - Defined: sel_out = pend | (HSELS & HREADYS), so IDLE/BUSY with HSELS keep the arbiter on this port.
  - Undefined: sel_out = pend | live_tran | (HSELS & HMASTLOCKS).

## Structure
- Shared package ahb_mtx_pkg holds:
  - HTRANS/HBURST encodings (TRN_IDLE/BUSY/NONSEQ/SEQ, BUR_*), shared with the arbiters.
  - HRESP encodings.
- Natural sub-module: ahb_mtx_hold_reg, the enable-loaded field register plus forwarding mux. Everything else is in the top.

## Test plan
- Live NONSEQ to 0x2000_0000 with active_in=1, readyout_in=1 -> same cycle: addr_out=0x2000_0000, held_tran=0. Next cycle: HREADYOUTS follows readyout_in.
- NONSEQ to 0x2000_0040 with active_in=0 for 3 cycles -> pend=1, held_tran=1, HREADYOUTS=0 for 3 cycles. Outputs stay held while HADDRS changes to 0x1234. After the grant, the data phase completes with HREADYOUTS=1.
- INCR4 burst granted throughout -> 4 live transfers, pend never set, HREADYOUTS tracks readyout_in per beat.
- resp_in=1 for 2 cycles with readyout_in=0 then 1 -> HRESPS=1 both cycles, HREADYOUTS 0 then 1.
- HRESETn low while pend=1 -> sel_out=0, HREADYOUTS=1, trans_out=IDLE, all immediately without waiting for a clock edge.
- IDLE with HSELS=1 -> sel_out=1 with AHB_MTX_IS_IDLE_HOLD_EN defined, 0 without. pend stays 0 in both builds.

Source files
------------

// File: rtl/ahb_mtx_pkg.sv
// Shared AHB bus-matrix encodings used by the input stages and the output-stage arbiters.
package ahb_mtx_pkg;

  typedef enum logic [1:0] {
    TRN_IDLE   = 2'b00,
    TRN_BUSY   = 2'b01,
    TRN_NONSEQ = 2'b10,
    TRN_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BUR_SINGLE = 3'b000,
    BUR_INCR   = 3'b001,
    BUR_WRAP4  = 3'b010,
    BUR_INCR4  = 3'b011,
    BUR_WRAP8  = 3'b100,
    BUR_INCR8  = 3'b101,
    BUR_WRAP16 = 3'b110,
    BUR_INCR16 = 3'b111
  } hburst_e;

  localparam logic RSP_OKAY  = 1'b0;
  localparam logic RSP_ERROR = 1'b1;

  // Input-stage state: a parked address phase and/or an outstanding data phase.
  typedef struct packed {
    logic pend;
    logic data_phase;
  } is_state_t;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY never request a transfer.
  function automatic logic trans_is_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_mtx_hold_reg.sv
// Address/control hold register of a matrix input stage plus the mux choosing
// between the live master address phase and the parked one.
module ahb_mtx_hold_reg
  import ahb_mtx_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              i_load,
  input  logic              i_use_held,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_trans,
  input  logic              i_write,
  input  logic [2:0]        i_size,
  input  logic [2:0]        i_burst,
  input  logic [3:0]        i_prot,
  input  logic              i_mastlock,
  output logic [ADDR_W-1:0] o_addr,
  output logic [1:0]        o_trans,
  output logic              o_write,
  output logic [2:0]        o_size,
  output logic [2:0]        o_burst,
  output logic [3:0]        o_prot,
  output logic              o_mastlock
);

  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_trans;
  logic              r_write;
  logic [2:0]        r_size;
  logic [2:0]        r_burst;
  logic [3:0]        r_prot;
  logic              r_mastlock;

  // Loaded on every HSELS & HREADYS cycle so the register always holds the
  // most recent address phase the master presented with the bus ready.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr     <= '0;
      r_trans    <= TRN_IDLE;
      r_write    <= 1'b0;
      r_size     <= '0;
      r_burst    <= BUR_SINGLE;
      r_prot     <= '0;
      r_mastlock <= 1'b0;
    end else if (i_load) begin
      r_addr     <= i_addr;
      r_trans    <= i_trans;
      r_write    <= i_write;
      r_size     <= i_size;
      r_burst    <= i_burst;
      r_prot     <= i_prot;
      r_mastlock <= i_mastlock;
    end
  end

  assign o_addr     = i_use_held ? r_addr     : i_addr;
  assign o_trans    = i_use_held ? r_trans    : i_trans;
  assign o_write    = i_use_held ? r_write    : i_write;
  assign o_size     = i_use_held ? r_size     : i_size;
  assign o_burst    = i_use_held ? r_burst    : i_burst;
  assign o_prot     = i_use_held ? r_prot     : i_prot;
  assign o_mastlock = i_use_held ? r_mastlock : i_mastlock;

endmodule

// File: rtl/ahb_mtx_input_stage.sv
// AHB bus-matrix input stage: forwards or parks the master's address phase and
// tracks its data phase. AHB_MTX_IS_IDLE_HOLD_EN keeps sel_out up on IDLE/BUSY.
module ahb_mtx_input_stage
  import ahb_mtx_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  output logic              sel_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [1:0]        trans_out,
  output logic              write_out,
  output logic [2:0]        size_out,
  output logic [2:0]        burst_out,
  output logic [3:0]        prot_out,
  output logic              mastlock_out,
  output logic              held_tran,
  input  logic              active_in,
  input  logic              readyout_in,
  input  logic              resp_in
);

  is_state_t r_state;
  is_state_t w_state_nxt;
  logic      w_live_tran;
  logic      w_addr_taken;
  logic      w_hold_load;
  logic      w_sel_keep;

  assign w_live_tran  = HSELS & HREADYS & trans_is_active(HTRANSS);
  assign w_addr_taken = active_in & readyout_in;
  assign w_hold_load  = HSELS & HREADYS;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= '0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A taken address phase always clears the park; the data phase that follows
  // belongs to whatever was forwarded, so IDLE/BUSY never open one.
  always_comb begin
    w_state_nxt = r_state;
    if (w_addr_taken) begin
      w_state_nxt.pend       = 1'b0;
      w_state_nxt.data_phase = trans_is_active(trans_out);
    end else begin
      w_state_nxt.pend = r_state.pend | w_live_tran;
      if (readyout_in) begin
        w_state_nxt.data_phase = 1'b0;
      end
    end
  end

  ahb_mtx_hold_reg #(
    .ADDR_W (ADDR_W)
  ) u_hold_reg (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .i_load     (w_hold_load),
    .i_use_held (r_state.pend),
    .i_addr     (HADDRS),
    .i_trans    (HTRANSS),
    .i_write    (HWRITES),
    .i_size     (HSIZES),
    .i_burst    (HBURSTS),
    .i_prot     (HPROTS),
    .i_mastlock (HMASTLOCKS),
    .o_addr     (addr_out),
    .o_trans    (trans_out),
    .o_write    (write_out),
    .o_size     (size_out),
    .o_burst    (burst_out),
    .o_prot     (prot_out),
    .o_mastlock (mastlock_out)
  );

`ifdef AHB_MTX_IS_IDLE_HOLD_EN
  assign w_sel_keep = HSELS & HREADYS;
`else
  assign w_sel_keep = w_live_tran | (HSELS & HMASTLOCKS);
`endif

  assign sel_out   = r_state.pend | w_sel_keep;
  assign held_tran = r_state.pend;

  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = RSP_OKAY;
    if (r_state.data_phase) begin
      HREADYOUTS = readyout_in;
      HRESPS     = resp_in;
    end else if (r_state.pend) begin
      HREADYOUTS = 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
// Directed and randomized bench for ahb_mtx_input_stage against a transaction-level model.
module tb_ahb_mtx_input_stage;
  import ahb_mtx_pkg::*;

  localparam int ADDR_W = 32;
`ifdef AHB_MTX_IS_IDLE_HOLD_EN
  localparam bit IDLE_HOLD = 1'b1;
`else
  localparam bit IDLE_HOLD = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              lock;
  } aphase_t;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic              HSELS;
  logic [ADDR_W-1:0] HADDRS;
  logic [1:0]        HTRANSS;
  logic              HWRITES;
  logic [2:0]        HSIZES;
  logic [2:0]        HBURSTS;
  logic [3:0]        HPROTS;
  logic              HMASTLOCKS;
  logic              HREADYS;
  logic              HREADYOUTS;
  logic              HRESPS;
  logic              sel_out;
  logic [ADDR_W-1:0] addr_out;
  logic [1:0]        trans_out;
  logic              write_out;
  logic [2:0]        size_out;
  logic [2:0]        burst_out;
  logic [3:0]        prot_out;
  logic              mastlock_out;
  logic              held_tran;
  logic              active_in;
  logic              readyout_in;
  logic              resp_in;

  // clock / reset
  always #5 HCLK = ~HCLK;

  // single-master view: the bus HREADY the master sees is this stage's own ready
  assign HREADYS = HREADYOUTS;

  ahb_mtx_input_stage #(.ADDR_W(ADDR_W)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .HSELS        (HSELS),
    .HADDRS       (HADDRS),
    .HTRANSS      (HTRANSS),
    .HWRITES      (HWRITES),
    .HSIZES       (HSIZES),
    .HBURSTS      (HBURSTS),
    .HPROTS       (HPROTS),
    .HMASTLOCKS   (HMASTLOCKS),
    .HREADYS      (HREADYS),
    .HREADYOUTS   (HREADYOUTS),
    .HRESPS       (HRESPS),
    .sel_out      (sel_out),
    .addr_out     (addr_out),
    .trans_out    (trans_out),
    .write_out    (write_out),
    .size_out     (size_out),
    .burst_out    (burst_out),
    .prot_out     (prot_out),
    .mastlock_out (mastlock_out),
    .held_tran    (held_tran),
    .active_in    (active_in),
    .readyout_in  (readyout_in),
    .resp_in      (resp_in)
  );

  // reference model: a parked transfer waiting for a grant, and an open data phase
  aphase_t     m_last;
  bit          m_waiting;
  bit          m_data;
  logic [45:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last    = '0;
    m_waiting = 1'b0;
    m_data    = 1'b0;
  endtask

  task automatic drive_ap(input logic sel, input logic [1:0] trans, input logic [ADDR_W-1:0] addr,
                          input logic wr, input logic [2:0] burst, input logic lock);
    HSELS      = sel;
    HTRANSS    = trans;
    HADDRS     = addr;
    HWRITES    = wr;
    HSIZES     = 3'b010;
    HBURSTS    = burst;
    HPROTS     = 4'b0011;
    HMASTLOCKS = lock;
  endtask

  task automatic drive_os(input logic act, input logic rdy, input logic rsp);
    active_in   = act;
    readyout_in = rdy;
    resp_in     = rsp;
  endtask

  // Check every output mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    aphase_t live;
    aphase_t fwd;
    bit      issue;
    bit      bus_ok;
    bit      taken;
    bit      rdy;
    @(negedge HCLK);
    live   = {HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};
    bus_ok = HSELS && HREADYS;
    issue  = bus_ok && (HTRANSS == TRN_NONSEQ || HTRANSS == TRN_SEQ);
    taken  = active_in && readyout_in;
    rdy    = readyout_in;
    fwd    = m_waiting ? m_last : live;
    exp_q.push_back(fwd);
    chk("fwd_phase", {addr_out, trans_out, write_out, size_out, burst_out, prot_out, mastlock_out},
        exp_q.pop_front());
    chk("held_tran", held_tran, m_waiting);
    chk("sel_out", sel_out,
        m_waiting || (IDLE_HOLD ? bus_ok : (issue || (HSELS && HMASTLOCKS))));
    chk("hreadyout", HREADYOUTS, m_data ? rdy : !m_waiting);
    chk("hresp", HRESPS, m_data ? resp_in : RSP_OKAY);
    chk("pend_dp_excl", dut.r_state.pend & dut.r_state.data_phase, 1'b0);
    @(posedge HCLK);
    if (bus_ok) m_last = live;
    if (taken) begin
      m_waiting = 1'b0;
      m_data    = (fwd.trans == TRN_NONSEQ || fwd.trans == TRN_SEQ);
    end else begin
      if (issue) m_waiting = 1'b1;
      if (rdy) m_data = 1'b0;
    end
    #1;
  endtask

  initial begin
    int beat;
    bit adv;
    HRESETn = 1'b0;
    drive_ap(1'b0, TRN_IDLE, '0, 1'b0, BUR_SINGLE, 1'b0);
    HSIZES = '0;
    HPROTS = '0;
    drive_os(1'b0, 1'b1, 1'b0);
    model_reset();
    #2;
    chk("rst_hreadyout", HREADYOUTS, 1'b1);
    chk("rst_hresp", HRESPS, 1'b0);
    chk("rst_sel", sel_out, 1'b0);
    chk("rst_held", held_tran, 1'b0);
    chk("rst_trans", trans_out, TRN_IDLE);
    chk("rst_addr", addr_out, 32'h0);
    #10 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // live pass-through, then data phase follows readyout_in
    drive_ap(1'b1, TRN_NONSEQ, 32'h2000_0000, 1'b0, BUR_SINGLE, 1'b0);
    drive_os(1'b1, 1'b1, 1'b0);
    #1;
    chk("s1_addr", addr_out, 32'h2000_0000);
    chk("s1_held", held_tran, 1'b0);
    step();
    drive_ap(1'b0, TRN_IDLE, '0, 1'b0, BUR_SINGLE, 1'b0);
    drive_os(1'b0, 1'b0, 1'b0);
    #1;
    chk("s1_dp_wait", HREADYOUTS, 1'b0);
    step();
    drive_os(1'b0, 1'b1, 1'b0);
    #1;
    chk("s1_dp_done", HREADYOUTS, 1'b1);
    step();

    // not granted: park, stall, keep held fields while HADDRS moves
    drive_ap(1'b1, TRN_NONSEQ, 32'h2000_0040, 1'b1, BUR_SINGLE, 1'b0);
    drive_os(1'b0, 1'b1, 1'b0);
    step();
    drive_ap(1'b1, TRN_NONSEQ, 32'h0000_1234, 1'b1, BUR_SINGLE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("s2_held", held_tran, 1'b1);
      chk("s2_addr", addr_out, 32'h2000_0040);
      chk("s2_stall", HREADYOUTS, 1'b0);
      step();
    end
    drive_os(1'b1, 1'b1, 1'b0);
    step();
    drive_ap(1'b0, TRN_IDLE, '0, 1'b0, BUR_SINGLE, 1'b0);
    drive_os(1'b0, 1'b1, 1'b0);
    #1;
    chk("s2_dp_done", HREADYOUTS, 1'b1);
    chk("s2_released", held_tran, 1'b0);
    step();

    // INCR4 burst with the port granted throughout, slave inserting random waits
    beat = 0;
    for (int c = 0; c < 24 && beat < 4; c++) begin
      drive_ap(1'b1, (beat == 0) ? TRN_NONSEQ : TRN_SEQ, 32'h3000_0000 + 32'(beat * 4),
               1'b0, BUR_INCR4, 1'b0);
      drive_os(1'b1, (beat == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0), 1'b0);
      #1;
      adv = HREADYS;
      chk("s3_no_hold", held_tran, 1'b0);
      step();
      if (adv) beat++;
    end
    chk("s3_beats", 32'(beat), 32'd4);
    drive_ap(1'b0, TRN_IDLE, '0, 1'b0, BUR_SINGLE, 1'b0);
    drive_os(1'b0, 1'b1, 1'b0);
    step();
    step();

    // two-cycle ERROR response passes through
    drive_ap(1'b1, TRN_NONSEQ, 32'h4000_0000, 1'b1, BUR_SINGLE, 1'b0);
    drive_os(1'b1, 1'b1, 1'b0);
    step();
    drive_ap(1'b0, TRN_IDLE, '0, 1'b0, BUR_SINGLE, 1'b0);
    drive_os(1'b0, 1'b0, 1'b1);
    #1;
    chk("s4_err1_resp", HRESPS, RSP_ERROR);
    chk("s4_err1_rdy", HREADYOUTS, 1'b0);
    step();
    drive_os(1'b0, 1'b1, 1'b1);
    #1;
    chk("s4_err2_resp", HRESPS, RSP_ERROR);
    chk("s4_err2_rdy", HREADYOUTS, 1'b1);
    step();
    drive_os(1'b0, 1'b1, 1'b0);
    step();

    // held locked transfer keeps mastlock_out until taken
    drive_ap(1'b1, TRN_NONSEQ, 32'h5000_0000, 1'b0, BUR_SINGLE, 1'b1);
    drive_os(1'b0, 1'b1, 1'b0);
    step();
    drive_ap(1'b1, TRN_IDLE, 32'h5000_0100, 1'b0, BUR_SINGLE, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("s5_lock_held", mastlock_out, 1'b1);
      step();
    end
    drive_os(1'b1, 1'b1, 1'b0);
    step();
    drive_ap(1'b0, TRN_IDLE, '0, 1'b0, BUR_SINGLE, 1'b0);
    drive_os(1'b0, 1'b1, 1'b0);
    #1;
    chk("s5_lock_gone", mastlock_out, 1'b0);
    step();

    // asynchronous reset while a transfer is parked
    drive_ap(1'b1, TRN_NONSEQ, 32'h6000_0000, 1'b0, BUR_SINGLE, 1'b0);
    drive_os(1'b0, 1'b1, 1'b0);
    step();
    #1;
    chk("s6_parked", held_tran, 1'b1);
    drive_ap(1'b0, TRN_IDLE, '0, 1'b0, BUR_SINGLE, 1'b0);
    HRESETn = 1'b0;
    #1;
    chk("s6_rst_sel", sel_out, 1'b0);
    chk("s6_rst_rdy", HREADYOUTS, 1'b1);
    chk("s6_rst_trans", trans_out, TRN_IDLE);
    chk("s6_rst_held", held_tran, 1'b0);
    chk("s6_rst_addr", addr_out, 32'h0);
    model_reset();
    #1 HRESETn = 1'b1;
    step();

    // IDLE with HSELS: sel_out depends on the build, never parks
    drive_ap(1'b1, TRN_IDLE, 32'h7000_0000, 1'b0, BUR_SINGLE, 1'b0);
    drive_os(1'b0, 1'b1, 1'b0);
    #1;
    chk("s7_idle_sel", sel_out, IDLE_HOLD);
    step();
    #1;
    chk("s7_no_pend", held_tran, 1'b0);
    drive_ap(1'b0, TRN_IDLE, '0, 1'b0, BUR_SINGLE, 1'b0);
    step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive_ap(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 5) == 0));
      HSIZES = 3'($urandom_range(0, 7));
      HPROTS = 4'($urandom_range(0, 15));
      drive_os(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 7) == 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
